imem_uart_loader: RTL and testbench
===================================

# imem_uart_loader

Serial program loader that writes 32-bit instruction words into instruction memory from a UART byte stream, so programs load without resynthesis. It is the writer side of the instruction-memory port that the single-cycle CPU reads. It contains an oversampled 8N1 receiver, a big-endian byte-to-word assembler and a word-address counter. While `load_en` is high the CPU is held in reset, and the loader owns the memory write port.

## Interface
- `CLKS_PER_BIT`, 434, clock cycles per UART bit (50 MHz / 115200); must be ≥ 8.
- `ADDR_W`, 7, word-address width; matches the 7-bit instruction-memory word index.
- `DEPTH`, 128, number of words loaded before `done`; must be ≤ 2^ADDR_W.
- `clock  input  1  system clock`
- `reset  input  1  reset, asynchronous, active-high`
- `rx  input  1  UART line; idle high; asynchronous to clock`
- `load_en  input  1  level; high = loader active; drives CPU reset externally`
- `we  output  1  one-cycle instruction-memory write strobe`
- `addr  output  ADDR_W  word address for the current write`
- `data  output  32  assembled instruction word`
- `busy  output  1  receiver mid-frame or partial word held`
- `done  output  1  sticky; DEPTH words written`
- `word_count  output  ADDR_W+1  words written since load start`
- `frame_err  output  1  sticky; a stop bit was sampled low`

## Operation
- `rx` passes through a 2-flop synchronizer. All receiver sampling uses the synchronized value.
- The receiver FSM has four states: IDLE, START, DATA, STOP.
  - IDLE -> START when the synchronized `rx` is 0 and `load_en` is 1.
  - In START, the line is sampled at count CLKS_PER_BIT/2. If it is 1, the start is false and the FSM returns to IDLE. If it is 0, the FSM goes to DATA.
  - In DATA, 8 bits are sampled LSB first, every CLKS_PER_BIT cycles after the start mid-point. Then the FSM goes to STOP.
  - In STOP, the line is sampled once. If it is 1, the byte is valid. If it is 0, `frame_err` is set, the byte is discarded and the lane counter is cleared (word resync). The FSM goes to IDLE in both cases.
- The assembler holds a 32-bit shift register and a 2-bit lane counter. Each valid byte shifts in as `shift = {shift[23:0], byte}`, so the first byte becomes bits [31:24].
- On the 4th byte of a word:
  - `data` takes the assembled word, and `we` pulses for 1 cycle with `addr` equal to the word pointer.
  - The pointer and `word_count` increment, and the lane counter returns to 0.
- When `word_count` reaches DEPTH, `done` is set. Further bytes are received but ignored: no `we`, and the pointer does not wrap.
- A rising edge of `load_en` is detected on a registered copy. It clears the pointer, `word_count`, the lane counter, the shift register, `done` and `frame_err`.
- A falling edge of `load_en` forces the FSM to IDLE and discards any partial word. `addr`, `data`, `word_count` and `done` hold their values.
- `busy` = (FSM ≠ IDLE) OR (lane counter ≠ 0).

## Timing
- Reset values: `we`=0, `addr`=0, `data`=0, `busy`=0, `done`=0, `word_count`=0, `frame_err`=0; FSM in IDLE.
- Reset has priority over everything, including mid-frame. Reset mid-frame discards the partial byte and word.
- Synchronizer latency is 2 cycles from an `rx` edge to the FSM seeing it.
- The byte is valid in the cycle of the stop-bit mid-point sample, S. `we`, `addr` and `data` are registered and appear at S+1. `word_count` updates at S+2 (the cycle after `we`). `done` rises in the same cycle as `word_count` reaches DEPTH.
- `addr` and `data` are stable throughout the `we` cycle. Memory writes on the `clock` edge at the end of that cycle.
- Back-to-back frames are supported: a start edge seen in the cycle the FSM enters IDLE begins the next frame.
- `we` is never asserted while `load_en`=0 or `done`=1.

## Test plan
Use CLKS_PER_BIT=16 and DEPTH=4 in simulation.
- Load with `load_en`=1 and send bytes 20 08 00 05 -> exactly one `we` pulse with `addr`=0 and `data`=0x20080005; `word_count`=1; `busy`=0 afterwards.
- Send 16 bytes forming words 0x11111111, 0x22222222, 0x33333333, 0x44444444 -> `we` at `addr` 0..3 with matching data; `done`=1 after the 4th word. A 17th-20th byte causes no `we` and leaves `addr` at 3.
- Send a 6-cycle low glitch on `rx` (false start), then byte 0xAB -> no frame started by the glitch; lane advances by exactly 1.
- Send bytes 0xDE and 0xAD, then a frame with its stop bit held 0, then 0xCA FE BA BE -> `frame_err`=1; the first `we` carries `data`=0xCAFEBABE at `addr`=0.
- Send 2 bytes, drop `load_en` for 100 cycles, raise it, send 4 bytes 0x01020304 -> `we` at `addr`=0 with `data`=0x01020304; `frame_err` and `done` are cleared on the rising edge.
- Assert `reset` at the middle of a data bit -> all outputs are at reset values in the next cycle; the following clean frame is received correctly.

Source files
------------

// File: rtl/imem_uart_loader.sv
// UART (8N1) program loader: assembles big-endian 32-bit words from a serial
// byte stream and writes them sequentially into instruction memory.
module imem_uart_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 7,
  parameter int DEPTH        = 128
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rx,
  input  logic              load_en,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [31:0]       data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_count,
  output logic              frame_err
);

  localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  HALF_CNT  = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  logic              rx_meta;
  logic              rx_sync;
  logic              load_en_q;
  logic              load_rise;
  logic              load_fall;

  rx_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        byte_q, byte_d;
  logic              byte_valid;
  logic              stop_bad;

  logic [31:0]       shift;
  logic [1:0]        lane;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   wc_next;
  logic [31:0]       word_next;

  // Two-flop synchronizer; idles high so reset does not look like a start bit.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      load_en_q <= 1'b0;
    end else begin
      rx_meta   <= rx;
      rx_sync   <= rx_meta;
      load_en_q <= load_en;
    end
  end

  assign load_rise = load_en & ~load_en_q;
  assign load_fall = ~load_en & load_en_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
    end
  end

  // NOTE: every variable gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    byte_d     = byte_q;
    byte_valid = 1'b0;
    stop_bad   = 1'b0;
    if (load_fall) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!rx_sync && load_en) begin
            state_d = START;
            cnt_d   = '0;
          end
        end
        START: begin
          if (cnt_q == HALF_CNT) begin
            cnt_d   = '0;
            bit_d   = '0;
            state_d = rx_sync ? IDLE : DATA;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == FULL_CNT) begin
            cnt_d  = '0;
            byte_d = {rx_sync, byte_q[7:1]};
            if (bit_q == 3'd7) state_d = STOP;
            else               bit_d   = bit_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (cnt_q == FULL_CNT) begin
            cnt_d      = '0;
            state_d    = IDLE;
            byte_valid = rx_sync;
            stop_bad   = ~rx_sync;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign wc_next   = word_count + 1'b1;
  assign word_next = {shift[23:0], byte_q};

  // Word assembler: pointer/count advance in the cycle after the write strobe,
  // so addr and data stay stable while we is high.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      we         <= 1'b0;
      addr       <= '0;
      data       <= '0;
      done       <= 1'b0;
      word_count <= '0;
      frame_err  <= 1'b0;
      shift      <= '0;
      lane       <= '0;
      ptr        <= '0;
    end else begin
      we <= 1'b0;
      if (load_rise) begin
        ptr        <= '0;
        word_count <= '0;
        lane       <= '0;
        shift      <= '0;
        done       <= 1'b0;
        frame_err  <= 1'b0;
      end else begin
        if (load_fall) lane <= '0;
        if (stop_bad) begin
          frame_err <= 1'b1;
          lane      <= '0;
        end
        if (byte_valid && !done) begin
          shift <= word_next;
          lane  <= lane + 2'd1;
          if (lane == 2'd3) begin
            we   <= 1'b1;
            addr <= ptr;
            data <= word_next;
          end
        end
        if (we) begin
          ptr        <= ptr + 1'b1;
          word_count <= wc_next;
          if (wc_next == DEPTH_CNT) done <= 1'b1;
        end
      end
    end
  end

  assign busy = (state_q != IDLE) || (lane != 2'd0);

endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed + randomized bench for imem_uart_loader against a byte-level
// reference model of the loader (words, lanes, pointer, sticky flags).
module tb_imem_uart_loader;

  localparam int CPB    = 16;
  localparam int ADDR_W = 7;
  localparam int DEPTH  = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic              rx;
  logic              load_en;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       data;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   word_count;
  logic              frame_err;

  imem_uart_loader #(
    .CLKS_PER_BIT(CPB),
    .ADDR_W      (ADDR_W),
    .DEPTH       (DEPTH)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .rx        (rx),
    .load_en   (load_en),
    .we        (we),
    .addr      (addr),
    .data      (data),
    .busy      (busy),
    .done      (done),
    .word_count(word_count),
    .frame_err (frame_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
  } wr_t;

  wr_t obs_q[$];
  wr_t exp_q[$];

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int          m_ptr, m_wc, m_lane;
  logic [31:0] m_word;
  bit          m_done, m_ferr;
  logic [31:0] m_last_addr, m_last_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Write monitor, sampled on the falling edge away from the active edge.
  always @(negedge clock) begin
    if (we === 1'b1) begin
      wr_t w;
      w.a = addr;
      w.d = data;
      obs_q.push_back(w);
      check("we_gate", 64'({load_en, done}), 64'(2'b10));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic m_reset();
    m_ptr = 0; m_wc = 0; m_lane = 0; m_word = '0;
    m_done = 0; m_ferr = 0; m_last_addr = '0; m_last_data = '0;
  endtask

  task automatic m_rise();
    m_ptr = 0; m_wc = 0; m_lane = 0; m_word = '0; m_done = 0; m_ferr = 0;
  endtask

  task automatic m_byte(input logic [7:0] b);
    wr_t w;
    if (m_done) return;
    m_word = {m_word[23:0], b};
    m_lane++;
    if (m_lane == 4) begin
      w.a = ADDR_W'(m_ptr);
      w.d = m_word;
      exp_q.push_back(w);
      m_last_addr = 32'(m_ptr);
      m_last_data = m_word;
      m_ptr++;
      m_wc++;
      m_lane = 0;
      if (m_wc == DEPTH) m_done = 1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    rx = 1'b0;
    cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cycles(CPB);
    end
    rx = stop_ok;
    cycles(CPB);
    rx = 1'b1;
    if (!stop_ok) cycles(2 * CPB);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b1);
    m_byte(b);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send(w[i*8 +: 8]);
  endtask

  task automatic set_load(input bit v);
    load_en = v;
    if (v) m_rise();
    else   m_lane = 0;
    cycles(4);
  endtask

  task automatic check_state(input string tag);
    cycles(4);
    check({tag, "_wr_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check($sformatf("%s_wr%0d_addr", tag, i), 64'(obs_q[i].a), 64'(exp_q[i].a));
      check($sformatf("%s_wr%0d_data", tag, i), 64'(obs_q[i].d), 64'(exp_q[i].d));
    end
    obs_q.delete();
    exp_q.delete();
    check({tag, "_word_count"}, 64'(word_count), 64'(m_wc));
    check({tag, "_done"},       64'(done),       64'(m_done));
    check({tag, "_frame_err"},  64'(frame_err),  64'(m_ferr));
    check({tag, "_busy"},       64'(busy),       64'(m_lane != 0));
    check({tag, "_addr"},       64'(addr),       64'(m_last_addr[ADDR_W-1:0]));
    check({tag, "_data"},       64'(data),       64'(m_last_data));
  endtask

  initial begin
    logic [7:0] r;
    reset   = 1'b1;
    rx      = 1'b1;
    load_en = 1'b0;
    m_reset();
    cycles(3);
    check("rst_we",         64'(we),         64'(0));
    check("rst_addr",       64'(addr),       64'(0));
    check("rst_data",       64'(data),       64'(0));
    check("rst_busy",       64'(busy),       64'(0));
    check("rst_done",       64'(done),       64'(0));
    check("rst_word_count", 64'(word_count), 64'(0));
    check("rst_frame_err",  64'(frame_err),  64'(0));
    reset = 1'b0;
    cycles(2);

    // Single word
    set_load(1'b1);
    send(8'h20); send(8'h08); send(8'h00); send(8'h05);
    check_state("single");

    // Fill to DEPTH, then overflow bytes are ignored
    set_load(1'b0);
    set_load(1'b1);
    send_word(32'h11111111);
    send_word(32'h22222222);
    send_word(32'h33333333);
    send_word(32'h44444444);
    check_state("fill");
    for (int i = 0; i < 4; i++) send(8'($urandom));
    check_state("overflow");

    // Glitch shorter than half a bit must not start a frame
    set_load(1'b0);
    set_load(1'b1);
    rx = 1'b0;
    cycles(6);
    rx = 1'b1;
    cycles(3 * CPB);
    check_state("glitch");
    send(8'hAB);
    check_state("glitch_ab");
    for (int i = 0; i < 3; i++) send(8'($urandom));
    check_state("glitch_word");

    // Framing error resynchronises the word
    set_load(1'b0);
    set_load(1'b1);
    send(8'hDE); send(8'hAD);
    send_frame(8'($urandom), 1'b0);
    m_ferr = 1; m_lane = 0;
    send_word(32'hCAFEBABE);
    check_state("ferr");
    for (int i = 0; i < 3; i++) send_word($urandom);
    check_state("ferr_fill");

    // load_en falling/rising edges
    send(8'($urandom)); send(8'($urandom));
    set_load(1'b0);
    cycles(100);
    check_state("drop_hold");
    set_load(1'b1);
    check_state("rise_clear");
    send(8'($urandom)); send(8'($urandom));
    check_state("partial");
    set_load(1'b0);
    cycles(100);
    check_state("partial_drop");
    set_load(1'b1);
    send_word(32'h01020304);
    check_state("reload");

    // Randomised words with random inter-frame gaps (including back-to-back)
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 4; j++) begin
        send(8'($urandom));
        cycles($urandom_range(0, 20));
      end
    end
    send(8'($urandom)); send(8'($urandom));
    check_state("random");

    // Reset in the middle of a data bit
    rx = 1'b0;
    cycles(CPB);
    r = 8'($urandom);
    rx = r[0];
    cycles(CPB);
    rx = r[1];
    cycles(CPB / 2);
    reset = 1'b1;
    m_reset();
    cycles(1);
    check("mid_rst_we",         64'(we),         64'(0));
    check("mid_rst_addr",       64'(addr),       64'(0));
    check("mid_rst_data",       64'(data),       64'(0));
    check("mid_rst_busy",       64'(busy),       64'(0));
    check("mid_rst_done",       64'(done),       64'(0));
    check("mid_rst_word_count", 64'(word_count), 64'(0));
    check("mid_rst_frame_err",  64'(frame_err),  64'(0));
    rx = 1'b1;
    cycles(1);
    reset = 1'b0;
    obs_q.delete();
    cycles(3 * CPB);
    send_word($urandom);
    check_state("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
